// File: rtl/cache_ctrl_2way.sv
// Sequencing controller for a 2-way set-associative cache.
// Holds valid/tag/dirty/lru metadata, resolves hit or miss, selects the
// victim, runs write-back and fill transactions over a req/ack handshake
// and steers the write strobes of the external data array.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for cpu_req; request fields are latched on accept
// LOOKUP   | one-cycle tag compare on both ways; hit write strobes data
// WRITEBACK| dirty victim goes to memory; mem_wr_req held until mem_ack
// FILL     | line fetched from memory; installed in the mem_ack cycle
// DONE     | one-cycle cpu_ready pulse, then back to IDLE

module cache_ctrl_2way #(
    parameter int TAG_W = 5,
    parameter int SET_W = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_write,
    input  logic [TAG_W+SET_W-1:0] cpu_addr,
    output logic                   cpu_busy,
    output logic                   cpu_ready,
    output logic                   cpu_hit,
    output logic [SET_W-1:0]       line_set,
    output logic                   way_sel,
    output logic                   data_we,
    output logic                   fill_sel,
    output logic                   mem_rd_req,
    output logic                   mem_wr_req,
    output logic [TAG_W+SET_W-1:0] mem_addr,
    input  logic                   mem_ack
);

    localparam int SETS = 2 ** SET_W;
    localparam int AW   = TAG_W + SET_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_WRITEBACK = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]       state;
    logic             write_q;
    logic [AW-1:0]    addr_q;
    logic             first_q;
    logic             hit_first_q;
    logic             victim_q;

    logic [1:0]       valid_q [SETS];
    logic [1:0]       dirty_q [SETS];
    logic [SETS-1:0]  lru_q;
    logic [TAG_W-1:0] tag_q   [SETS][2];

    logic [SET_W-1:0] set_idx;
    logic [TAG_W-1:0] tag_l;
    logic [1:0]       hit_w;
    logic             hit_any;
    logic             hit_way;
    logic             victim_c;

    assign set_idx = addr_q[SET_W-1:0];
    assign tag_l   = addr_q[AW-1:SET_W];

    // Tag compare on both ways and victim choice: invalid ways first, then lru.
    always_comb begin
        hit_w[0] = valid_q[set_idx][0] && (tag_q[set_idx][0] == tag_l);
        hit_w[1] = valid_q[set_idx][1] && (tag_q[set_idx][1] == tag_l);
        hit_any  = |hit_w;
        hit_way  = hit_w[1];
        if (!valid_q[set_idx][0]) begin
            victim_c = 1'b0;
        end else if (!valid_q[set_idx][1]) begin
            victim_c = 1'b1;
        end else begin
            victim_c = lru_q[set_idx];
        end
    end

    // Output decode; memory requests depend on state only, so they are stable.
    always_comb begin
        cpu_busy   = (state != S_IDLE);
        cpu_ready  = (state == S_DONE);
        cpu_hit    = (state == S_DONE) && hit_first_q;
        line_set   = set_idx;
        way_sel    = 1'b0;
        data_we    = 1'b0;
        fill_sel   = 1'b0;
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        case (state)
            S_LOOKUP: begin
                if (hit_any) begin
                    way_sel = hit_way;
                    data_we = write_q;
                end
            end
            S_WRITEBACK: begin
                mem_wr_req = 1'b1;
                mem_addr   = {tag_q[set_idx][victim_q], set_idx};
                way_sel    = victim_q;
            end
            S_FILL: begin
                mem_rd_req = 1'b1;
                mem_addr   = addr_q;
                way_sel    = victim_q;
                if (mem_ack) begin
                    data_we  = 1'b1;
                    fill_sel = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Controller state and valid/dirty/lru metadata; reset wipes every line.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            first_q     <= 1'b0;
            hit_first_q <= 1'b0;
            victim_q    <= 1'b0;
            lru_q       <= '0;
            for (int i = 0; i < SETS; i++) begin
                valid_q[i] <= 2'b00;
                dirty_q[i] <= 2'b00;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        write_q     <= cpu_write;
                        addr_q      <= cpu_addr;
                        hit_first_q <= 1'b0;
                        first_q     <= 1'b1;
                        state       <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit_any) begin
                        lru_q[set_idx] <= ~hit_way;
                        if (write_q) begin
                            dirty_q[set_idx][hit_way] <= 1'b1;
                        end
                        hit_first_q <= first_q;
                        state       <= S_DONE;
                    end else begin
                        first_q  <= 1'b0;
                        victim_q <= victim_c;
                        if (valid_q[set_idx][victim_c] && dirty_q[set_idx][victim_c]) begin
                            state <= S_WRITEBACK;
                        end else begin
                            state <= S_FILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) begin
                        dirty_q[set_idx][victim_q] <= 1'b0;
                        state                      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        valid_q[set_idx][victim_q] <= 1'b1;
                        dirty_q[set_idx][victim_q] <= 1'b0;
                        lru_q[set_idx]             <= ~victim_q;
                        state                      <= S_LOOKUP;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Tag install on fill; tags carry no reset since valid gates every compare.
    always_ff @(posedge clock) begin
        if (!reset && (state == S_FILL) && mem_ack) begin
            tag_q[set_idx][victim_q] <= tag_l;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Bench for cache_ctrl_2way: directed scenarios followed by random accesses,
// each compared against a line-level cache model kept in the bench.
module tb_cache_ctrl_2way;

    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req;
    logic       cpu_write;
    logic [5:0] cpu_addr;
    logic       cpu_busy;
    logic       cpu_ready;
    logic       cpu_hit;
    logic [0:0] line_set;
    logic       way_sel;
    logic       data_we;
    logic       fill_sel;
    logic       mem_rd_req;
    logic       mem_wr_req;
    logic [5:0] mem_addr;
    logic       mem_ack;

    cache_ctrl_2way #(.TAG_W(5), .SET_W(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_busy   (cpu_busy),
        .cpu_ready  (cpu_ready),
        .cpu_hit    (cpu_hit),
        .line_set   (line_set),
        .way_sel    (way_sel),
        .data_we    (data_we),
        .fill_sel   (fill_sel),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    // reference model: line metadata per set/way
    bit         m_valid [2][2];
    bit         m_dirty [2][2];
    logic [4:0] m_tag   [2][2];
    bit         m_lru   [2];

    // model predictions
    bit         e_hit;
    bit         e_wb;
    logic [5:0] e_wb_addr;
    int         e_victim;
    int         e_way;
    int         e_lat;

    // observations from one access
    int         o_lat;
    bit         o_ready_seen;
    int         o_ready_cnt;
    logic       o_hit;
    bit         o_wr_seen;
    logic [5:0] o_wr_addr;
    logic       o_wr_way;
    bit         o_rd_seen;
    logic [5:0] o_rd_addr;
    logic       o_rd_way;
    int         o_unstable;
    int         o_both;
    int         o_we_fill;
    int         o_we_cpu;
    logic       o_fill_way;
    logic       o_cpu_way;
    int         o_we_bad;
    int         o_set_bad;
    int         o_busy_after;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
        end
    endtask

    // Predict outcome/latency of one access from the cache rules, then commit it.
    task automatic model_access(input logic wr, input logic [5:0] addr, input int kw, input int kf);
        int         s;
        int         hw;
        logic [4:0] t;
        s  = int'(addr[0]);
        t  = addr[5:1];
        hw = -1;
        for (int w = 0; w < 2; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
        end
        e_wb      = 1'b0;
        e_wb_addr = '0;
        e_victim  = 0;
        if (hw >= 0) begin
            e_hit = 1'b1;
            e_lat = 2;
        end else begin
            e_hit = 1'b0;
            if (!m_valid[s][0])      e_victim = 0;
            else if (!m_valid[s][1]) e_victim = 1;
            else                     e_victim = int'(m_lru[s]);
            e_wb      = m_valid[s][e_victim] && m_dirty[s][e_victim];
            e_wb_addr = {m_tag[s][e_victim], addr[0]};
            e_lat     = e_wb ? (5 + kw + kf) : (4 + kf);
            m_valid[s][e_victim] = 1'b1;
            m_tag[s][e_victim]   = t;
            m_dirty[s][e_victim] = 1'b0;
            hw = e_victim;
        end
        e_way    = hw;
        m_lru[s] = (hw == 0);
        if (wr) m_dirty[s][hw] = 1'b1;
    endtask

    // Drive one request, answer memory with the given ack delays, record what happened.
    task automatic run_access(input logic wr, input logic [5:0] addr, input int kw, input int kf, input bit hold);
        int cyc;
        int wr_start;
        int rd_start;
        int ready_cyc;
        cyc = 0; wr_start = -1; rd_start = -1; ready_cyc = -1;
        o_lat = 0; o_ready_cnt = 0; o_hit = 1'b0; o_wr_seen = 0; o_wr_addr = '0; o_wr_way = 1'b0;
        o_rd_seen = 0; o_rd_addr = '0; o_rd_way = 1'b0; o_unstable = 0; o_both = 0;
        o_we_fill = 0; o_we_cpu = 0; o_fill_way = 1'b0; o_cpu_way = 1'b0; o_we_bad = 0;
        o_set_bad = 0; o_busy_after = 0;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr; mem_ack = 1'b0;
        while (cyc < 80 && (ready_cyc < 0 || cyc < ready_cyc + 3)) begin
            @(posedge clock); #1;
            cyc++;
            if (!hold || ready_cyc >= 0) cpu_req = 1'b0;
            mem_ack = 1'b0;
            if (mem_wr_req) begin
                if (wr_start < 0) begin
                    wr_start = cyc; o_wr_seen = 1; o_wr_addr = mem_addr; o_wr_way = way_sel;
                end else if (mem_addr !== o_wr_addr) begin
                    o_unstable++;
                end
                if (cyc - wr_start == kw) mem_ack = 1'b1;
            end
            if (mem_rd_req) begin
                if (rd_start < 0) begin
                    rd_start = cyc; o_rd_seen = 1; o_rd_addr = mem_addr; o_rd_way = way_sel;
                end else if (mem_addr !== o_rd_addr) begin
                    o_unstable++;
                end
                if (cyc - rd_start == kf) mem_ack = 1'b1;
            end
            #1;
            if (mem_wr_req && mem_rd_req) o_both++;
            if (cpu_busy && line_set !== addr[0:0]) o_set_bad++;
            if (data_we) begin
                if (fill_sel) begin
                    o_we_fill++; o_fill_way = way_sel;
                    if (!(mem_rd_req && mem_ack)) o_we_bad++;
                end else begin
                    o_we_cpu++; o_cpu_way = way_sel;
                end
            end
            if (cpu_ready) begin
                o_ready_cnt++;
                if (ready_cyc < 0) begin
                    ready_cyc = cyc; o_lat = cyc; o_hit = cpu_hit;
                end
            end
            if (ready_cyc >= 0 && cyc > ready_cyc && cpu_busy) o_busy_after++;
        end
        cpu_req = 1'b0;
        mem_ack = 1'b0;
        o_ready_seen = (ready_cyc >= 0);
    endtask

    task automatic access(input string nm, input logic wr, input logic [5:0] addr, input int kw, input int kf, input bit hold);
        model_access(wr, addr, kw, kf);
        run_access(wr, addr, kw, kf, hold);
        chk({nm, ".ready_seen"}, 32'(o_ready_seen), 32'd1);
        chk({nm, ".ready_cnt"}, 32'(o_ready_cnt), 32'd1);
        chk({nm, ".latency"}, 32'(o_lat), 32'(e_lat));
        chk({nm, ".cpu_hit"}, 32'(o_hit), 32'(e_hit));
        chk({nm, ".wr_req_seen"}, 32'(o_wr_seen), 32'(e_wb));
        if (e_wb) begin
            chk({nm, ".wb_addr"}, 32'(o_wr_addr), 32'(e_wb_addr));
            chk({nm, ".wb_way"}, 32'(o_wr_way), 32'(e_victim));
        end
        chk({nm, ".rd_req_seen"}, 32'(o_rd_seen), 32'(!e_hit));
        if (!e_hit) begin
            chk({nm, ".fill_addr"}, 32'(o_rd_addr), 32'(addr));
            chk({nm, ".fill_way_req"}, 32'(o_rd_way), 32'(e_victim));
            chk({nm, ".fill_way_we"}, 32'(o_fill_way), 32'(e_victim));
        end
        chk({nm, ".we_fill_cnt"}, 32'(o_we_fill), e_hit ? 32'd0 : 32'd1);
        chk({nm, ".we_cpu_cnt"}, 32'(o_we_cpu), 32'(wr));
        if (wr) chk({nm, ".cpu_we_way"}, 32'(o_cpu_way), 32'(e_way));
        chk({nm, ".addr_stable"}, 32'(o_unstable), 32'd0);
        chk({nm, ".both_req"}, 32'(o_both), 32'd0);
        chk({nm, ".we_outside_ack"}, 32'(o_we_bad), 32'd0);
        chk({nm, ".line_set"}, 32'(o_set_bad), 32'd0);
        chk({nm, ".busy_after_done"}, 32'(o_busy_after), 32'd0);
    endtask

    function automatic logic [14:0] all_outs();
        return {cpu_busy, cpu_ready, cpu_hit, line_set, way_sel, data_we, fill_sel,
                mem_rd_req, mem_wr_req, mem_addr};
    endfunction

    initial begin
        logic       wr;
        logic [5:0] a;
        int         kw;
        int         kf;
        bit         hold;

        reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; mem_ack = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1 chk("reset_outputs", 32'(all_outs()), 32'd0);

        // read miss into empty set, fill ack two cycles after request
        access("t1_read_miss", 1'b0, 6'b001000, 0, 2, 1'b0);
        // same line again: hit in two cycles
        access("t2_read_hit", 1'b0, 6'b001000, 0, 0, 1'b0);
        // write miss: fill into way 1, then hit-write
        access("t3_write_miss", 1'b1, 6'b001010, 0, 1, 1'b0);
        // way 0 is clean lru, then tag 7 evicts dirty way 1 with a slow write-back
        access("t4_read_tag6", 1'b0, 6'b001100, 0, 0, 1'b0);
        access("t4_read_tag7_wb", 1'b0, 6'b001110, 3, 1, 1'b0);

        // make both ways dirty, then start a miss that must write back
        access("t5_write_tag7", 1'b1, 6'b001110, 0, 0, 1'b0);
        access("t5_write_tag6", 1'b1, 6'b001100, 0, 0, 1'b0);
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 6'b010000;
        @(posedge clock); #1;
        cpu_req = 1'b0;
        @(posedge clock); #2;
        chk("t5_in_writeback", 32'(mem_wr_req), 32'd1);
        chk("t5_wb_addr", 32'(mem_addr), 32'(6'b001110));
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1 chk("t5_reset_outputs", 32'(all_outs()), 32'd0);
        model_reset();
        access("t5_after_reset_miss", 1'b0, 6'b001010, 0, 1, 1'b0);

        // stray acks while idle must do nothing
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            mem_ack = 1'b1;
            #1 chk("t6_idle_ack", 32'({cpu_busy, cpu_ready, data_we, mem_rd_req, mem_wr_req}), 32'd0);
        end
        @(posedge clock); #1;
        mem_ack = 1'b0;
        // request held through DONE gives only one completion
        access("t6_hold_hit", 1'b0, 6'b001010, 0, 0, 1'b1);
        access("t6_hold_miss", 1'b1, 6'b000011, 0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            wr   = 1'($urandom_range(0, 1));
            a    = 6'($urandom_range(0, 7));
            kw   = int'($urandom_range(0, 3));
            kf   = int'($urandom_range(0, 3));
            hold = 1'($urandom_range(0, 1));
            access("rand", wr, a, kw, kf, hold);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_2way.md
Name: cache_ctrl_2way

Overview:
- Sequencing controller for the 2-way set-associative cache (2 sets, 5-bit tag, 8-bit line payload).
- Owns line metadata: valid, tag, LRU and dirty. Accepts one CPU request at a time.
- Decides hit/miss, picks the victim, issues write-back and fill requests to memory over a req/ack handshake, and drives the write strobes of the external data array.
- Sits between the CPU port and the memory port; the data array sits beside it and is steered by way_sel/line_set/data_we/fill_sel.

Parameters:
- TAG_W, 5, tag width (address bits [TAG_W+SET_W-1:SET_W]).
- SET_W, 1, set-index width; sets = 2**SET_W; ways fixed at 2.

Ports:
- clock  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  request strobe, sampled only in IDLE.
- cpu_write  in  1  1=write, 0=read; latched with cpu_req.
- cpu_addr  in  TAG_W+SET_W  {tag, set}; latched with cpu_req.
- cpu_busy  out  1  high whenever state != IDLE.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_hit  out  1  valid with cpu_ready; 1 if the first lookup hit.
- line_set  out  SET_W  set index of the current access (latched addr).
- way_sel  out  1  way addressed in the data array.
- data_we  out  1  one-cycle data-array write strobe.
- fill_sel  out  1  data source for data_we: 0=CPU data, 1=memory data.
- mem_rd_req  out  1  fill request, held until mem_ack.
- mem_wr_req  out  1  write-back request, held until mem_ack.
- mem_addr  out  TAG_W+SET_W  {tag, set} of the memory transaction.
- mem_ack  in  1  memory completion; ignored when no request is pending.

Behaviour:

Reset:
- State becomes IDLE.
- All valid, dirty and lru bits are cleared to 0; tags are don't-care.
- All outputs are 0.
- A reset during any state aborts the operation. mem_*_req drop the cycle after reset is sampled. Dirty data is discarded.

Metadata:
- Per set, per way: valid, tag, dirty.
- Per set: one lru bit, naming the way to evict next.
- Any hit or fill on way w sets lru[set] = ~w.

States:
- IDLE:
  - On cpu_req=1, latch cpu_write and cpu_addr, clear the hit_first flag, set the first flag, and go to LOOKUP.
  - With cpu_req=0, stay in IDLE.
- LOOKUP (1 cycle): hit = valid & (tag == latched tag), checked on both ways. A double match is impossible by construction.
  - On a hit on way w:
    - way_sel = w; update lru.
    - If write: data_we=1, fill_sel=0, dirty[set][w]=1.
    - cpu_hit register = first flag.
    - Go to DONE.
  - On a miss:
    - Clear the first flag.
    - Victim = way 0 if invalid, else way 1 if invalid, else lru[set].
    - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - mem_wr_req=1, mem_addr={victim tag, set}, way_sel=victim.
  - Held stable until mem_ack; then clear dirty on the victim and go to FILL.
- FILL:
  - mem_rd_req=1, mem_addr=latched addr, way_sel=victim.
  - Held until mem_ack. In the mem_ack cycle: data_we=1, fill_sel=1, and install valid=1, tag=latched tag, dirty=0.
  - Then go to LOOKUP. The re-lookup hits and performs the CPU write when one is pending.
- DONE:
  - cpu_ready=1 for one cycle, with cpu_hit as recorded.
  - Go to IDLE. A cpu_req asserted in DONE is ignored and must be reasserted in IDLE.

Latency and handshake rules:
- Hit: cpu_req sampled at edge N gives cpu_ready high in cycle N+2.
- Clean miss with an ack k cycles after the request rises: cpu_ready appears 3+k cycles after LOOKUP.
- mem_rd_req and mem_wr_req are never high together.
- A mem_ack arriving in the same cycle a request first rises is accepted.
- data_we is never asserted outside LOOKUP-hit-write or the FILL ack cycle.

Test Plan:
1. After reset, read addr 6'b001000 (tag 4, set 0):
   - LOOKUP misses; FILL raises mem_rd_req with mem_addr=6'b001000.
   - ack after 2 cycles → data_we=1, fill_sel=1, way_sel=0.
   - cpu_ready pulses with cpu_hit=0.
2. Repeat the read of 6'b001000 → cpu_ready exactly 2 cycles after cpu_req, cpu_hit=1, no memory request, lru[0]=1.
3. Write 6'b001010 (tag 5, set 0) → miss, fill into way 1; the re-lookup asserts data_we with fill_sel=0; dirty[0][1]=1; lru[0]=0.
4. Read 6'b001100 (tag 6, set 0); way 0 is clean LRU → no write-back, fill into way 0. Then read tag 7, set 0:
   - Victim is way 1, which is dirty.
   - mem_wr_req with mem_addr=6'b001010 is held across 3 cycles of no ack.
   - After ack, mem_rd_req follows with mem_addr=6'b001110.
5. Assert reset while in WRITEBACK → next cycle all outputs are 0 and state is IDLE; then a read of tag 5, set 0 misses (valid cleared).
6. Spurious mem_ack in IDLE, and cpu_req held through DONE → no state change; exactly one cpu_ready per accepted request.
